// File: rtl/udp_rx_unpacker.sv
// udp_rx_unpacker: gathers a UDP payload byte stream into one left-aligned word handed off by valid/ready
module udp_rx_unpacker #(
    parameter int MAX_BYTES = 120
) (
    input  logic                   rgmii_clk,
    input  logic                   rstn,
    input  logic                   udp_rec_data_valid,
    input  logic [7:0]             udp_rec_rdata,
    input  logic [15:0]            udp_rec_data_length,
    output logic                   rx_data_valid,
    input  logic                   rx_data_ready,
    output logic [MAX_BYTES*8-1:0] rx_data,
    output logic [15:0]            rx_data_length,
    output logic                   rx_truncated,
    output logic                   rx_len_err,
    output logic [15:0]            rx_drop_cnt
);
    localparam int IW = $clog2(MAX_BYTES);
    typedef enum logic [2:0] {IDLE, COLLECT, HOLD, HOLD_DISC, DISC} state_t;
    state_t      state;
    logic        dv_d;
    logic        start;
    logic        capture;
    logic [15:0] cnt;
    logic [15:0] len_lat;
    logic [7:0]  mem [MAX_BYTES];
    assign start   = udp_rec_data_valid & ~dv_d;
    assign capture = start & ((state == IDLE) | ((state == HOLD) & rx_data_ready));
    for (genvar g = 0; g < MAX_BYTES; g++) begin : g_out
        assign rx_data[MAX_BYTES*8-1-8*g -: 8] = mem[g];
    end
    always_ff @(posedge rgmii_clk) begin
        if (!rstn) begin
            state          <= IDLE;
            dv_d           <= 1'b1;
            cnt            <= '0;
            len_lat        <= '0;
            mem            <= '{default: 8'h00};
            rx_data_valid  <= 1'b0;
            rx_data_length <= '0;
            rx_truncated   <= 1'b0;
            rx_len_err     <= 1'b0;
            rx_drop_cnt    <= '0;
        end else begin
            dv_d <= udp_rec_data_valid;
            if (capture) begin
                state         <= COLLECT;
                rx_data_valid <= 1'b0;
                mem           <= '{default: 8'h00};
                mem[0]        <= udp_rec_rdata;
                cnt           <= 16'd1;
                len_lat       <= udp_rec_data_length;
            end else begin
                case (state)
                    COLLECT: begin
                        if (udp_rec_data_valid) begin
                            if (cnt < 16'(MAX_BYTES)) mem[cnt[IW-1:0]] <= udp_rec_rdata;
                            cnt <= cnt + 16'(cnt != 16'hFFFF);
                        end else begin
                            state          <= HOLD;
                            rx_data_valid  <= 1'b1;
                            rx_data_length <= cnt;
                            rx_truncated   <= cnt > 16'(MAX_BYTES);
                            rx_len_err     <= cnt != len_lat;
                        end
                    end
                    HOLD: begin
                        if (rx_data_ready) begin
                            state         <= IDLE;
                            rx_data_valid <= 1'b0;
                        end else if (start) begin
                            state <= HOLD_DISC;
                        end
                    end
                    HOLD_DISC: begin
                        if (rx_data_ready & udp_rec_data_valid) begin
                            state         <= DISC;
                            rx_data_valid <= 1'b0;
                        end else if (!udp_rec_data_valid) begin
                            state         <= rx_data_ready ? IDLE : HOLD;
                            rx_data_valid <= ~rx_data_ready;
                            rx_drop_cnt   <= rx_drop_cnt + 16'd1;
                        end
                    end
                    DISC: begin
                        if (!udp_rec_data_valid) begin
                            state       <= IDLE;
                            rx_drop_cnt <= rx_drop_cnt + 16'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_udp_rx_unpacker.sv
// tb_udp_rx_unpacker: directed and random datagrams checked against a transaction-level model
module tb_udp_rx_unpacker;
    localparam int MB = 120;
    logic          rgmii_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          udp_rec_data_valid = 1'b0;
    logic [7:0]    udp_rec_rdata = 8'h00;
    logic [15:0]   udp_rec_data_length = 16'h0000;
    logic          rx_data_ready = 1'b0;
    logic          rx_data_valid;
    logic [MB*8-1:0] rx_data;
    logic [15:0]   rx_data_length;
    logic          rx_truncated;
    logic          rx_len_err;
    logic [15:0]   rx_drop_cnt;

    udp_rx_unpacker #(.MAX_BYTES(MB)) dut (
        .rgmii_clk(rgmii_clk), .rstn(rstn),
        .udp_rec_data_valid(udp_rec_data_valid), .udp_rec_rdata(udp_rec_rdata),
        .udp_rec_data_length(udp_rec_data_length),
        .rx_data_valid(rx_data_valid), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
        .rx_data_length(rx_data_length), .rx_truncated(rx_truncated),
        .rx_len_err(rx_len_err), .rx_drop_cnt(rx_drop_cnt)
    );

    always #4 rgmii_clk = ~rgmii_clk;

    int checks = 0;
    int errors = 0;
    // model: a word is held or not; each datagram is captured, dropped or ignored (0 none, 1 capture, 2 drop)
    logic          m_held = 1'b0;
    logic          m_prev_v = 1'b1;
    int            m_fate = 0;
    logic [7:0]    m_q[$];
    logic [15:0]   m_lf = 16'h0000;
    logic [MB*8-1:0] e_data = '0;
    int            e_len = 0;
    logic          e_trunc = 1'b0;
    logic          e_lerr = 1'b0;
    int            e_drop = 0;
    logic [7:0]    dead[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_word();
        for (int k = 0; k < 8; k++)
            check($sformatf("rx_data[%0d]", k), 128'(rx_data[k*120 +: 120]), 128'(e_data[k*120 +: 120]));
        check("rx_data_length", 128'(rx_data_length), 128'(e_len[15:0]));
        check("rx_truncated", 128'(rx_truncated), 128'(e_trunc));
        check("rx_len_err", 128'(rx_len_err), 128'(e_lerr));
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
        logic st;
        int n;
        if (!rstn) begin
            m_held = 1'b0;
            m_fate = 0;
            m_prev_v = 1'b1;
            e_drop = 0;
        end else begin
            st = v & ~m_prev_v;
            if (st) m_fate = (!m_held || r) ? 1 : 2;
            if (m_held && r) m_held = 1'b0;
            if (st && m_fate == 1) begin
                m_q.delete();
                m_lf = udp_rec_data_length;
            end
            if (v && m_fate == 1) m_q.push_back(d);
            if (!v && m_prev_v && m_fate != 0) begin
                if (m_fate == 1) begin
                    n = m_q.size();
                    e_data = '0;
                    for (int i = 0; i < MB; i++) e_data = {e_data[MB*8-9:0], (i < n) ? m_q[i] : 8'h00};
                    e_len = (n > 65535) ? 65535 : n;
                    e_trunc = n > MB;
                    e_lerr = n != int'(m_lf);
                    m_held = 1'b1;
                end else begin
                    e_drop++;
                end
                m_fate = 0;
            end
            m_prev_v = v;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        udp_rec_data_valid = v;
        udp_rec_rdata = d;
        rx_data_ready = r;
        @(posedge rgmii_clk);
        model_edge(v, d, r);
        #1;
        check("rx_data_valid", 128'(rx_data_valid), 128'(m_held));
        check("rx_drop_cnt", 128'(rx_drop_cnt), 128'(e_drop[15:0]));
        if (m_held) check_word();
    endtask

    function automatic logic rdy(input int rm, input logic first);
        return rm == 0 ? 1'b0 : rm == 1 ? 1'b1 : rm == 3 ? first : 1'($urandom_range(0, 1));
    endfunction

    // rm: 0 ready low, 1 ready high, 2 random, 3 high only on the first byte; base < 0 gives random bytes
    task automatic send(input int n, input int lf, input int gap, input int rm, input int base);
        udp_rec_data_length = 16'(lf);
        for (int i = 0; i < n; i++) step(1'b1, base < 0 ? 8'($urandom) : 8'(base + i), rdy(rm, i == 0));
        for (int i = 0; i < gap; i++) step(1'b0, 8'h00, rdy(rm, 1'b0));
    endtask

    initial begin
        rstn = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        e_data = '0; e_len = 0; e_trunc = 1'b0; e_lerr = 1'b0;
        check_word();
        rstn = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        udp_rec_data_length = 16'd4;
        for (int i = 0; i < 4; i++) step(1'b1, dead[i], 1'b1);
        step(1'b0, 8'h00, 1'b1);
        check("deadbeef", 128'(rx_data[959:928]), 128'(32'hDEADBEEF));
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        send(130, 130, 2, 1, 0);
        send(8, 10, 2, 1, -1);
        send(6, 6, 2, 0, -1);
        send(5, 5, 2, 0, -1);
        send(3, 3, 2, 0, -1);
        check("drop_two", 128'(rx_drop_cnt), 128'(16'd2));
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        send(4, 4, 2, 0, -1);
        send(3, 3, 2, 3, 8'h55);
        check("byte0_55", 128'(rx_data[959:952]), 128'(8'h55));
        step(1'b0, 8'h00, 1'b1);
        udp_rec_data_length = 16'd9;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b1);
        rstn = 1'b0;
        step(1'b1, 8'h33, 1'b1);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 4), 1'b1);
        step(1'b0, 8'h00, 1'b1);
        send(4, 4, 2, 1, -1);
        send(3, 3, 2, 0, -1);
        rstn = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        rstn = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        repeat (60) begin
            int n, lf;
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(110, 135)) : int'($urandom_range(1, 16));
            lf = ($urandom_range(0, 3) == 0) ? n + int'($urandom_range(1, 3)) : n;
            send(n, lf, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), -1);
        end
        repeat (3) step(1'b0, 8'h00, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
